chain_core_seq: RTL and testbench

Parametrised, time-multiplexed successor to the rope-simulation core: holds `NODES` chain nodes and relaxes them with one shared relaxation unit, one node per cycle, Gauss-Seidel order, for a programmable number of passes per `start`. Sits in the same chain-of-cores arrangement as the current core: it exchanges boundary nodes with its neighbours, pins the chain head and optionally drags the chain tail to the mouse. It adds a start/busy/done handshake, configurable width, depth and pass count, and a runtime node-load port.

---
 rtl/chain_pkg.sv | 25 ++
 rtl/chain_relax_unit.sv | 23 ++
 rtl/chain_core_seq.sv | 162 ++++++++++++++++
 tb/tb_chain_core_seq.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/chain_pkg.sv
// Shared types and helpers for the time-multiplexed chain relaxation core.
// Holds the FSM state encoding, default geometry and the floor-halve arithmetic helper.
package chain_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SWEEP = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam int DEF_W       = 32;
   localparam int DEF_SPACING = 16;

   // Power-up x position of a node; every node starts at y = 0.
   function automatic logic signed [63:0] layout_x(input int core_id, input int nodes,
                                                   input int idx, input int spacing);
      return 64'(((core_id - 1) * nodes + idx) * spacing);
   endfunction

   // Arithmetic shift rounds toward minus infinity, e.g. -3 -> -2.
   function automatic logic signed [63:0] floor_halve(input logic signed [63:0] v);
      return v >>> 1;
   endfunction

endpackage

// File: rtl/chain_relax_unit.sv
// One axis of the relaxation step: new = floor((cur + floor((prev + next) / 2)) / 2).
// Sums carry one guard bit so two full-range coordinates never overflow before halving.
module chain_relax_unit
   import chain_pkg::*;
#(
   parameter int W = DEF_W
) (
   input  logic signed [W-1:0] i_prev,
   input  logic signed [W-1:0] i_cur,
   input  logic signed [W-1:0] i_next,
   output logic signed [W-1:0] o_new
);

   logic signed [W:0]   w_sum_pn;
   logic signed [W:0]   w_sum_ct;
   logic signed [W-1:0] w_t;

   assign w_sum_pn = {i_prev[W-1], i_prev} + {i_next[W-1], i_next};
   assign w_t      = W'(floor_halve(64'(w_sum_pn)));
   assign w_sum_ct = {i_cur[W-1], i_cur} + {w_t[W-1], w_t};
   assign o_new    = W'(floor_halve(64'(w_sum_ct)));

endmodule

// File: rtl/chain_core_seq.sv
// Chain core holding NODES nodes, relaxed one node per cycle in Gauss-Seidel order
// by a single shared relaxation unit per axis, for a programmable number of passes.
module chain_core_seq
   import chain_pkg::*;
#(
   parameter int NODES   = 5,
   parameter int W       = DEF_W,
   parameter int CORE_ID = 1,
   parameter int SPACING = DEF_SPACING,
   parameter int ITER_W  = 4,
   localparam int IW     = $clog2(NODES)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [ITER_W-1:0]     iterations,
   input  logic                  is_first,
   input  logic                  is_last,
   input  logic                  mouse_en,
   input  logic signed [W-1:0]   mouse_x,
   input  logic signed [W-1:0]   mouse_y,
   input  logic signed [W-1:0]   prev_last_x,
   input  logic signed [W-1:0]   prev_last_y,
   input  logic signed [W-1:0]   next_first_x,
   input  logic signed [W-1:0]   next_first_y,
   input  logic                  init_we,
   input  logic [IW-1:0]         init_idx,
   input  logic signed [W-1:0]   init_x,
   input  logic signed [W-1:0]   init_y,
   output logic                  busy,
   output logic                  done,
   output logic [NODES*W-1:0]    nodes_x,
   output logic [NODES*W-1:0]    nodes_y
);

   state_t              r_state;
   state_t              w_state_next;
   logic [IW-1:0]       r_idx;
   logic [ITER_W-1:0]   r_pass;
   logic [ITER_W-1:0]   r_passes;

   logic signed [W-1:0] r_x [NODES];
   logic signed [W-1:0] r_y [NODES];
   logic signed [W-1:0] w_lay_x [NODES];
   logic signed [W-1:0] w_lo_x [NODES];
   logic signed [W-1:0] w_lo_y [NODES];
   logic signed [W-1:0] w_hi_x [NODES];
   logic signed [W-1:0] w_hi_y [NODES];

   logic signed [W-1:0] w_prev_x, w_prev_y, w_cur_x, w_cur_y, w_next_x, w_next_y;
   logic signed [W-1:0] w_rel_x, w_rel_y, w_wr_x, w_wr_y;
   logic                w_idx_last, w_last_slot, w_upd, w_load;

   // Per-node neighbour taps: chain ends look across to the adjacent cores.
   generate
      for (genvar gi = 0; gi < NODES; gi++) begin : gen_node
         localparam logic signed [63:0] LAY_X = layout_x(CORE_ID, NODES, gi, SPACING);
         assign w_lay_x[gi] = LAY_X[W-1:0];
         if (gi == 0) begin : gen_lo_ext
            assign w_lo_x[gi] = prev_last_x;
            assign w_lo_y[gi] = prev_last_y;
         end else begin : gen_lo_int
            assign w_lo_x[gi] = r_x[gi-1];
            assign w_lo_y[gi] = r_y[gi-1];
         end
         if (gi == NODES - 1) begin : gen_hi_ext
            assign w_hi_x[gi] = next_first_x;
            assign w_hi_y[gi] = next_first_y;
         end else begin : gen_hi_int
            assign w_hi_x[gi] = r_x[gi+1];
            assign w_hi_y[gi] = r_y[gi+1];
         end
         assign nodes_x[gi*W +: W] = r_x[gi];
         assign nodes_y[gi*W +: W] = r_y[gi];
      end
   endgenerate

   assign w_idx_last  = (r_idx == IW'(NODES - 1));
   assign w_last_slot = w_idx_last && (r_pass == r_passes - ITER_W'(1));
   assign w_upd       = (r_state == SWEEP);
   assign w_load      = (r_state == IDLE) && init_we;

   assign w_prev_x = w_lo_x[r_idx];
   assign w_prev_y = w_lo_y[r_idx];
   assign w_cur_x  = r_x[r_idx];
   assign w_cur_y  = r_y[r_idx];
   assign w_next_x = w_hi_x[r_idx];
   assign w_next_y = w_hi_y[r_idx];

   chain_relax_unit #(.W(W)) u_relax_x (
      .i_prev(w_prev_x), .i_cur(w_cur_x), .i_next(w_next_x), .o_new(w_rel_x)
   );
   chain_relax_unit #(.W(W)) u_relax_y (
      .i_prev(w_prev_y), .i_cur(w_cur_y), .i_next(w_next_y), .o_new(w_rel_y)
   );

   always_comb begin
      w_wr_x = w_rel_x;
      w_wr_y = w_rel_y;
      if ((r_idx == '0) && is_first) begin
         w_wr_x = w_cur_x;
         w_wr_y = w_cur_y;
      end else if (w_idx_last && is_last) begin
         w_wr_x = mouse_en ? mouse_x : w_cur_x;
         w_wr_y = mouse_en ? mouse_y : w_cur_y;
      end
   end

   // Loads only happen in IDLE and updates only in SWEEP, so they never collide.
   always_ff @(posedge clk) begin
      for (int i = 0; i < NODES; i++) begin
         if (reset) begin
            r_x[i] <= w_lay_x[i];
            r_y[i] <= '0;
         end else if (w_upd && (r_idx == IW'(i))) begin
            r_x[i] <= w_wr_x;
            r_y[i] <= w_wr_y;
         end else if (w_load && (init_idx == IW'(i))) begin
            r_x[i] <= init_x;
            r_y[i] <= init_y;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE:    if (start) w_state_next = SWEEP;
         SWEEP:   if (w_last_slot) w_state_next = DONE;
         DONE:    w_state_next = IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_idx    <= '0;
         r_pass   <= '0;
         r_passes <= '0;
      end else if ((r_state == IDLE) && start) begin
         r_idx    <= '0;
         r_pass   <= '0;
         r_passes <= (iterations == '0) ? ITER_W'(1) : iterations;
      end else if (r_state == SWEEP) begin
         if (w_idx_last) begin
            r_idx  <= '0;
            r_pass <= r_pass + ITER_W'(1);
         end else begin
            r_idx  <= r_idx + IW'(1);
         end
      end
   end

   assign busy = (r_state == SWEEP);
   assign done = (r_state == DONE);

endmodule

// File: tb/tb_chain_core_seq.sv
// Self-checking bench for chain_core_seq: hand-computed vector table, corner-case
// sequences, and randomized runs compared against an arithmetic reference model.
module tb_chain_core_seq;

   localparam int N   = 5;
   localparam int W   = 32;
   localparam int CID = 1;
   localparam int SP  = 16;

   logic                clk = 1'b0;
   logic                reset = 1'b1;
   logic                start = 1'b0;
   logic [3:0]          iterations = '0;
   logic                is_first = 1'b1, is_last = 1'b1, mouse_en = 1'b0;
   logic signed [W-1:0] mouse_x = '0, mouse_y = '0;
   logic signed [W-1:0] prev_last_x = '0, prev_last_y = '0;
   logic signed [W-1:0] next_first_x = '0, next_first_y = '0;
   logic                init_we = 1'b0;
   logic [2:0]          init_idx = '0;
   logic signed [W-1:0] init_x = '0, init_y = '0;
   logic                busy, done;
   logic [N*W-1:0]      nodes_x, nodes_y;

   int n_total = 0;
   int n_bad   = 0;

   chain_core_seq #(.NODES(N), .W(W), .CORE_ID(CID), .SPACING(SP), .ITER_W(4)) dut (
      .clk(clk), .reset(reset), .start(start), .iterations(iterations),
      .is_first(is_first), .is_last(is_last), .mouse_en(mouse_en),
      .mouse_x(mouse_x), .mouse_y(mouse_y),
      .prev_last_x(prev_last_x), .prev_last_y(prev_last_y),
      .next_first_x(next_first_x), .next_first_y(next_first_y),
      .init_we(init_we), .init_idx(init_idx), .init_x(init_x), .init_y(init_y),
      .busy(busy), .done(done), .nodes_x(nodes_x), .nodes_y(nodes_y)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- reference model ----------------
   longint m_x [N];
   longint m_y [N];

   function automatic longint fhalf(input longint v);
      if (v >= 0) return v / 2;
      return -((-v + 1) / 2);
   endfunction

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin
         m_x[i] = longint'(((CID - 1) * N + i) * SP);
         m_y[i] = 0;
      end
   endtask

   task automatic model_load(input int idx, input longint x, input longint y);
      if (idx < N) begin
         m_x[idx] = x;
         m_y[idx] = y;
      end
   endtask

   task automatic model_run(input int iters);
      int p;
      longint px, py, nx, ny;
      p = (iters == 0) ? 1 : iters;
      for (int pass = 0; pass < p; pass++) begin
         for (int i = 0; i < N; i++) begin
            if (i == 0 && is_first) continue;
            if (i == N - 1 && is_last) begin
               if (mouse_en) begin
                  m_x[i] = mouse_x;
                  m_y[i] = mouse_y;
               end
               continue;
            end
            if (i == 0) begin px = prev_last_x; py = prev_last_y; end
            else        begin px = m_x[i-1];    py = m_y[i-1];    end
            if (i == N - 1) begin nx = next_first_x; ny = next_first_y; end
            else            begin nx = m_x[i+1];     ny = m_y[i+1];     end
            m_x[i] = fhalf(m_x[i] + fhalf(px + nx));
            m_y[i] = fhalf(m_y[i] + fhalf(py + ny));
         end
      end
   endtask

   // ---------------- helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic longint dut_x(input int i);
      logic signed [W-1:0] v;
      v = nodes_x[i*W +: W];
      return v;
   endfunction

   function automatic longint dut_y(input int i);
      logic signed [W-1:0] v;
      v = nodes_y[i*W +: W];
      return v;
   endfunction

   task automatic check(input string name, input longint got, input longint exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   task automatic check_model_nodes(input string tag);
      for (int i = 0; i < N; i++) begin
         check($sformatf("%s x[%0d]", tag, i), dut_x(i), m_x[i]);
         check($sformatf("%s y[%0d]", tag, i), dut_y(i), m_y[i]);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      model_reset();
   endtask

   task automatic do_load(input int idx, input int x, input int y);
      init_we  = 1'b1;
      init_idx = 3'(idx);
      init_x   = x;
      init_y   = y;
      tick();
      init_we  = 1'b0;
      model_load(idx, x, y);
   endtask

   // Starts a run and checks busy/done every cycle through the first idle cycle.
   // dist_k: cycle in which start and init_we are pulsed during the sweep (0 = none).
   // rst_k : cycle in which reset is asserted (0 = none).
   task automatic run_check(input int iters, input int dist_k, input int rst_k, input string tag);
      int p, bad_k;
      logic eb, ed, gb, gd;
      p = (iters == 0) ? 1 : iters;
      bad_k = -1;
      gb = 0; gd = 0; eb = 0; ed = 0;
      start = 1'b1;
      iterations = 4'(iters);
      tick();
      start = 1'b0;
      init_we = 1'b0;
      for (int k = 1; k <= N * p + 2; k++) begin
         logic xb, xd;
         xb = (k <= N * p) && !(rst_k != 0 && k > rst_k);
         xd = (k == N * p + 1) && !(rst_k != 0 && k > rst_k);
         if (bad_k < 0 && (busy !== xb || done !== xd)) begin
            bad_k = k; gb = busy; gd = done; eb = xb; ed = xd;
         end
         if (k == dist_k) begin
            start = 1'b1; iterations = 4'd3;
            init_we = 1'b1; init_idx = 3'd2; init_x = 777; init_y = 777;
         end
         if (k == rst_k) reset = 1'b1;
         tick();
         start = 1'b0; init_we = 1'b0; reset = 1'b0;
      end
      n_total++;
      if (bad_k >= 0) begin
         n_bad++;
         $display("FAIL %s timing cycle %0d: got busy=%0b done=%0b expected busy=%0b done=%0b",
                  tag, bad_k, gb, gd, eb, ed);
      end
   endtask

   function automatic int rnd_val();
      case ($urandom_range(0, 2))
         0:       return int'($urandom_range(0, 128)) - 64;
         1:       return int'($urandom_range(0, 200000)) - 100000;
         default: return int'($urandom);
      endcase
   endfunction

   // ---------------- vector table ----------------
   typedef logic [N-1:0][31:0] nvec_t;

   typedef struct {
      string name;
      int    iters;
      bit    first, last, men;
      int    mx, my, plx, ply, nfx, nfy;
      bit    ld, ld_with_start;
      int    li, lx, ly;
      nvec_t ex, ey;
   } vec_t;

   function automatic nvec_t pack5(input int a0, input int a1, input int a2, input int a3, input int a4);
      nvec_t r;
      r[0] = a0; r[1] = a1; r[2] = a2; r[3] = a3; r[4] = a4;
      return r;
   endfunction

   vec_t tv [6];

   initial begin
      longint lay;

      tv[0] = '{"base",      1, 1, 1, 0,   0,  0,  0,  0,  0, 0, 0, 0, 0,  0,   0,
                pack5(0, 16, 32, 48, 64), pack5(0, 0, 0, 0, 0)};
      tv[1] = '{"load_n2",   1, 1, 1, 0,   0,  0,  0,  0,  0, 0, 1, 1, 2, 32,  40,
                pack5(0, 16, 32, 48, 64), pack5(0, 10, 22, 5, 0)};
      tv[2] = '{"mouse",     0, 1, 1, 1, 100, -8,  0,  0,  0, 0, 0, 0, 0,  0,   0,
                pack5(0, 16, 32, 48, 100), pack5(0, 0, 0, 0, -8)};
      tv[3] = '{"floor",     1, 0, 1, 0,   0,  0, -3, -3,  0, 0, 1, 0, 1,  0,   0,
                pack5(-1, 7, 29, 47, 64), pack5(-1, -1, -1, -1, 0)};
      tv[4] = '{"tail_free", 2, 1, 0, 0,   0,  0,  0,  0, 80, 7, 0, 0, 0,  0,   0,
                pack5(0, 16, 32, 48, 64), pack5(0, 0, 0, 0, 2)};
      tv[5] = '{"oor_load",  1, 1, 1, 0,   0,  0,  0,  0,  0, 0, 1, 0, 6, 999, -999,
                pack5(0, 16, 32, 48, 64), pack5(0, 0, 0, 0, 0)};

      // Reset state
      do_reset();
      check("reset busy", longint'(busy), 0);
      check("reset done", longint'(done), 0);
      for (int i = 0; i < N; i++) begin
         lay = longint'(i * SP);
         check($sformatf("reset x[%0d]", i), dut_x(i), lay);
         check($sformatf("reset y[%0d]", i), dut_y(i), 0);
      end

      // Table-driven vectors
      for (int v = 0; v < 6; v++) begin
         do_reset();
         is_first = tv[v].first; is_last = tv[v].last; mouse_en = tv[v].men;
         mouse_x = tv[v].mx; mouse_y = tv[v].my;
         prev_last_x = tv[v].plx; prev_last_y = tv[v].ply;
         next_first_x = tv[v].nfx; next_first_y = tv[v].nfy;
         if (tv[v].ld && !tv[v].ld_with_start) do_load(tv[v].li, tv[v].lx, tv[v].ly);
         if (tv[v].ld && tv[v].ld_with_start) begin
            init_we = 1'b1; init_idx = 3'(tv[v].li); init_x = tv[v].lx; init_y = tv[v].ly;
         end
         run_check(tv[v].iters, 0, 0, tv[v].name);
         for (int i = 0; i < N; i++) begin
            check($sformatf("%s x[%0d]", tv[v].name, i), dut_x(i), longint'($signed(tv[v].ex[i])));
            check($sformatf("%s y[%0d]", tv[v].name, i), dut_y(i), longint'($signed(tv[v].ey[i])));
         end
      end

      // start and init_we pulsed mid-sweep are ignored
      is_first = 1; is_last = 1; mouse_en = 0;
      prev_last_x = 0; prev_last_y = 0; next_first_x = 0; next_first_y = 0;
      do_reset();
      run_check(1, 2, 0, "disturb");
      model_run(1);
      check_model_nodes("disturb");
      tick();
      check("disturb no restart busy", longint'(busy), 0);

      // Reset in cycle 3 of a two-pass run aborts it
      do_reset();
      do_load(2, 32, 40);
      run_check(2, 0, 3, "midreset");
      model_reset();
      check_model_nodes("midreset");

      // Randomized runs against the reference model
      for (int r = 0; r < 30; r++) begin
         int nl, it;
         do_reset();
         is_first = 1'($urandom_range(0, 1));
         is_last  = 1'($urandom_range(0, 1));
         mouse_en = 1'($urandom_range(0, 1));
         mouse_x = rnd_val(); mouse_y = rnd_val();
         prev_last_x = rnd_val(); prev_last_y = rnd_val();
         next_first_x = rnd_val(); next_first_y = rnd_val();
         nl = $urandom_range(0, 4);
         for (int l = 0; l < nl; l++) do_load($urandom_range(0, 7), rnd_val(), rnd_val());
         it = $urandom_range(0, 3);
         run_check(it, 0, 0, $sformatf("rand%0d", r));
         model_run(it);
         check_model_nodes($sformatf("rand%0d", r));
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
